// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds and runs an external pattern generator, compacts the
// circuit-under-test responses in a MISR and compares the result against a golden signature.
module bist_ctrl #(
  parameter int unsigned         NUM_BITS  = 8,
  parameter int unsigned         CNT_W     = 16,
  parameter logic [NUM_BITS-1:0] MISR_POLY = 8'h1D
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_patterns,
  input  logic [NUM_BITS-1:0] golden_sig,
  input  logic [NUM_BITS-1:0] cut_resp,
  output logic                lfsr_rst_n,
  output logic                lfsr_stop,
  output logic                pattern_valid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cfg_err,
  output logic [NUM_BITS-1:0] signature
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    RUN     = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] golden_q, golden_d;
  logic [NUM_BITS-1:0] misr_q, misr_d;
  logic [NUM_BITS-1:0] sig_q, sig_d;
  logic                pass_q, pass_d;
  logic                cfg_err_q, cfg_err_d;
  logic                lfsr_rst_n_q, lfsr_rst_n_d;
  logic                lfsr_stop_q, lfsr_stop_d;
  logic                pv_q, pv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  function automatic logic [NUM_BITS-1:0] misr_step(input logic [NUM_BITS-1:0] cur,
                                                    input logic [NUM_BITS-1:0] resp);
    misr_step = {cur[NUM_BITS-2:0], 1'b0} ^ ({NUM_BITS{cur[NUM_BITS-1]}} & MISR_POLY) ^ resp;
  endfunction

  // Next-state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    golden_d  = golden_q;
    misr_d    = misr_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    cfg_err_d = cfg_err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (num_patterns != '0) begin
            state_d   = SEED;
            cnt_d     = num_patterns;
            golden_d  = golden_sig;
            misr_d    = '0;
            pass_d    = 1'b0;
            cfg_err_d = 1'b0;
          end else begin
            state_d   = DONE;
            pass_d    = 1'b0;
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      SEED: state_d = RUN;
      RUN: begin
        misr_d = misr_step(misr_q, cut_resp);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = COMPARE;
        end else begin
          state_d = RUN;
        end
      end
      COMPARE: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == golden_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start; results are kept
    if (abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      golden_d  = golden_q;
      misr_d    = misr_q;
      sig_d     = sig_q;
      pass_d    = 1'b0;
      cfg_err_d = cfg_err_q;
    end else begin
      state_d = state_d;
    end

    lfsr_rst_n_d = (state_d != SEED);
    lfsr_stop_d  = !((state_d == SEED) || (state_d == RUN));
    pv_d         = (state_d == RUN);
    busy_d       = (state_d == SEED) || (state_d == RUN) || (state_d == COMPARE);
    done_d       = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      golden_q     <= '0;
      misr_q       <= '0;
      sig_q        <= '0;
      pass_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      lfsr_rst_n_q <= 1'b1;
      lfsr_stop_q  <= 1'b1;
      pv_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      golden_q     <= golden_d;
      misr_q       <= misr_d;
      sig_q        <= sig_d;
      pass_q       <= pass_d;
      cfg_err_q    <= cfg_err_d;
      lfsr_rst_n_q <= lfsr_rst_n_d;
      lfsr_stop_q  <= lfsr_stop_d;
      pv_q         <= pv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lfsr_rst_n    = lfsr_rst_n_q;
  assign lfsr_stop     = lfsr_stop_q;
  assign pattern_valid = pv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign cfg_err       = cfg_err_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl (4-bit MISR, poly 4'b0011, 4-bit pattern counter);
// expected signature/pass pairs are queued at start and popped when DONE is reached.
module tb_bist_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] num_patterns = 4'd0;
  logic [3:0] golden_sig = 4'd0;
  logic [3:0] cut_resp = 4'd0;
  logic       lfsr_rst_n, lfsr_stop, pattern_valid, busy, done, pass, cfg_err;
  logic [3:0] signature;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] resp_q[$];
  logic [4:0] sb_q[$];
  logic [3:0] last_sig = 4'd0;

  bist_ctrl #(.NUM_BITS(4), .CNT_W(4), .MISR_POLY(4'b0011)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .num_patterns(num_patterns), .golden_sig(golden_sig), .cut_resp(cut_resp),
    .lfsr_rst_n(lfsr_rst_n), .lfsr_stop(lfsr_stop), .pattern_valid(pattern_valid),
    .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] misr_model(input logic [3:0] m, input logic [3:0] r);
    logic [3:0] fb;
    fb = m[3] ? 4'b0011 : 4'b0000;
    return {m[2:0], 1'b0} ^ fb ^ r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    resp_q.delete();
    for (int i = 0; i < n; i++) resp_q.push_back(4'($urandom_range(0, 15)));
  endtask

  // One complete accepted run; responses come from resp_q
  task automatic run_bist(input int n, input logic [3:0] golden, input bit noisy_start);
    logic [3:0] m;
    logic [4:0] exp;
    m = 4'd0;
    for (int i = 0; i < n; i++) m = misr_model(m, resp_q[i]);
    sb_q.push_back({m, (m == golden)});
    num_patterns = 4'(n);
    golden_sig   = golden;
    start        = 1'b1;
    step();
    start = 1'b0;
    check_eq("seed_busy", 32'(busy), 32'd1);
    check_eq("seed_lfsr_rst_n", 32'(lfsr_rst_n), 32'd0);
    check_eq("seed_lfsr_stop", 32'(lfsr_stop), 32'd0);
    check_eq("seed_pv", 32'(pattern_valid), 32'd0);
    check_eq("seed_cfg_err", 32'(cfg_err), 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq("run_pv", 32'(pattern_valid), 32'd1);
      check_eq("run_lfsr_rst_n", 32'(lfsr_rst_n), 32'd1);
      check_eq("run_lfsr_stop", 32'(lfsr_stop), 32'd0);
      cut_resp = resp_q[i];
      if (noisy_start) begin
        start        = 1'($urandom_range(0, 1));
        num_patterns = 4'($urandom_range(0, 15));
      end
    end
    step();
    start    = 1'b0;
    cut_resp = 4'($urandom_range(0, 15));
    check_eq("cmp_pv", 32'(pattern_valid), 32'd0);
    check_eq("cmp_lfsr_stop", 32'(lfsr_stop), 32'd1);
    check_eq("cmp_busy", 32'(busy), 32'd1);
    check_eq("cmp_done", 32'(done), 32'd0);
    step();
    check_eq("done_flag", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_lfsr_stop", 32'(lfsr_stop), 32'd1);
    check_eq("done_cfg_err", 32'(cfg_err), 32'd0);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_eq("signature", 32'(signature), 32'(exp[4:1]));
      check_eq("pass", 32'(pass), 32'(exp[0]));
      last_sig = exp[4:1];
      step();
      check_eq("done_hold", 32'(done), 32'd1);
      check_eq("sig_hold", 32'(signature), 32'(exp[4:1]));
      check_eq("pass_hold", 32'(pass), 32'(exp[0]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_lfsr_rst_n", 32'(lfsr_rst_n), 32'd1);
    check_eq("rst_lfsr_stop", 32'(lfsr_stop), 32'd1);
    check_eq("rst_pv", 32'(pattern_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_signature", 32'(signature), 32'd0);
    step();
    n_rst = 1'b1;
    step();

    // Directed signature scenarios: match, mismatch, MISR feedback
    resp_q = '{4'd1, 4'd2, 4'd4};
    run_bist(3, 4'h4, 1'b0);
    resp_q = '{4'd1, 4'd2, 4'd4};
    run_bist(3, 4'h5, 1'b0);
    resp_q = '{4'b1000, 4'b0000};
    run_bist(2, 4'b0011, 1'b0);

    // Zero pattern count: straight to DONE with cfg_err, no pattern ever valid
    num_patterns = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("cfg_done", 32'(done), 32'd1);
    check_eq("cfg_err", 32'(cfg_err), 32'd1);
    check_eq("cfg_pass", 32'(pass), 32'd0);
    check_eq("cfg_sig_kept", 32'(signature), 32'(last_sig));
    check_eq("cfg_pv", 32'(pattern_valid), 32'd0);
    step();
    check_eq("cfg_pv_hold", 32'(pattern_valid), 32'd0);
    check_eq("cfg_err_hold", 32'(cfg_err), 32'd1);

    // Boundaries and random runs; start noise while busy must be ignored
    fill_random(1);
    run_bist(1, 4'($urandom_range(0, 15)), 1'b0);
    fill_random(15);
    run_bist(15, 4'($urandom_range(0, 15)), 1'b1);
    for (int k = 0; k < 6; k++) begin
      int n;
      logic [3:0] m;
      n = $urandom_range(1, 15);
      fill_random(n);
      m = 4'd0;
      for (int i = 0; i < n; i++) m = misr_model(m, resp_q[i]);
      run_bist(n, (k % 2 == 0) ? m : (m ^ 4'd1), 1'b1);
    end

    // Abort together with start in the second RUN cycle of a 10-pattern run
    num_patterns = 4'd10;
    golden_sig   = 4'd0;
    start        = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("ab_pre_pv", 32'(pattern_valid), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_eq("ab_busy", 32'(busy), 32'd0);
    check_eq("ab_done", 32'(done), 32'd0);
    check_eq("ab_lfsr_stop", 32'(lfsr_stop), 32'd1);
    check_eq("ab_lfsr_rst_n", 32'(lfsr_rst_n), 32'd1);
    check_eq("ab_pv", 32'(pattern_valid), 32'd0);
    check_eq("ab_pass", 32'(pass), 32'd0);
    check_eq("ab_sig_kept", 32'(signature), 32'(last_sig));
    step();
    check_eq("ab_start_ignored", 32'(busy), 32'd0);

    // Reset asserted mid-run, then a fresh run must complete
    fill_random(8);
    num_patterns = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_pv", 32'(pattern_valid), 32'd0);
    check_eq("mrst_lfsr_stop", 32'(lfsr_stop), 32'd1);
    check_eq("mrst_lfsr_rst_n", 32'(lfsr_rst_n), 32'd1);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_signature", 32'(signature), 32'd0);
    step();
    n_rst = 1'b1;
    step();
    check_eq("mrst_idle", 32'(busy), 32'd0);
    fill_random(5);
    run_bist(5, 4'd0, 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
